// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
// A queue entry holds the predicted direction and the recovery PC.
package bru_pkg;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_PC_W  = 32;
   localparam int DEF_CNT_W = 16;

   typedef struct packed {
      logic                taken;
      logic [DEF_PC_W-1:0] alt_pc;
   } bru_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX-facing bundle of the branch resolve unit.
// The master drives predictions and resolutions; the slave is the unit itself.
interface branch_resolve_unit_if
   import bru_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int CNT_W = DEF_CNT_W
);

   logic             pred_valid;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_alt_pc;
   logic             res_valid;
   logic             res_taken;
   logic             upd_en;
   logic             upd_taken;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic             q_full;
   logic             err;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   modport master (
      output pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
      input  upd_en, upd_taken, flush, redirect_pc, q_full, err,
             branch_cnt, mispred_cnt
   );

   modport slave (
      input  pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
      output upd_en, upd_taken, flush, redirect_pc, q_full, err,
             branch_cnt, mispred_cnt
   );

endinterface

// File: rtl/bru_pred_fifo.sv
// In-order queue of outstanding predictions with a single-cycle clear.
// The caller guarantees push/pop are only asserted when legal.
module bru_pred_fifo
   import bru_pkg::*;
#(
   parameter int  DEPTH   = DEF_DEPTH,
   parameter type entry_t = bru_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  logic   clear,
   input  entry_t wr_data,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W:0]   count_r;

   // Entry storage; a push that coincides with a clear is a squashed branch.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else if (clear) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = (count_r == (PTR_W+1)'(DEPTH));
   assign empty = (count_r == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued predictions against EX outcomes in order, trains the
// predictor, issues a one-cycle flush on mispredict and keeps statistics.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PC_W  = DEF_PC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic                  clk,
   input logic                  rst_n,
   branch_resolve_unit_if.slave bus
);

   typedef struct packed {
      logic            taken;
      logic [PC_W-1:0] alt_pc;
   } entry_t;

   entry_t           wr_entry_s;
   entry_t           head_s;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             mispred_s;
   logic             push_s;
   logic             push_err_s;
   logic             pop_err_s;

   logic             upd_en_r;
   logic             upd_taken_r;
   logic             flush_r;
   logic [PC_W-1:0]  redirect_pc_r;
   logic             err_r;
   logic [CNT_W-1:0] branch_cnt_r;
   logic [CNT_W-1:0] mispred_cnt_r;

   // Resolve/push decisions; a mispredict squashes any same-cycle push.
   always_comb begin
      wr_entry_s        = '0;
      wr_entry_s.taken  = bus.pred_taken;
      wr_entry_s.alt_pc = bus.pred_alt_pc;
      pop_s      = bus.res_valid && !empty_s;
      mispred_s  = pop_s && (head_s.taken != bus.res_taken);
      push_s     = bus.pred_valid && !mispred_s && (!full_s || pop_s);
      push_err_s = bus.pred_valid && full_s && !pop_s;
      pop_err_s  = bus.res_valid && empty_s;
   end

   bru_pred_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .pop     (pop_s),
      .clear   (mispred_s),
      .wr_data (wr_entry_s),
      .head    (head_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   // One-cycle training and redirect pulses following each resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_en_r      <= 1'b0;
         upd_taken_r   <= 1'b0;
         flush_r       <= 1'b0;
         redirect_pc_r <= '0;
      end else begin
         upd_en_r      <= pop_s;
         upd_taken_r   <= pop_s && bus.res_taken;
         flush_r       <= mispred_s;
         redirect_pc_r <= mispred_s ? head_s.alt_pc : '0;
      end
   end

   // Saturating statistics and the sticky protocol error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_r  <= '0;
         mispred_cnt_r <= '0;
         err_r         <= 1'b0;
      end else begin
         if (pop_s && (branch_cnt_r != '1)) begin
            branch_cnt_r <= branch_cnt_r + CNT_W'(1);
         end
         if (mispred_s && (mispred_cnt_r != '1)) begin
            mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
         end
         if (push_err_s || pop_err_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign bus.upd_en      = upd_en_r;
   assign bus.upd_taken   = upd_taken_r;
   assign bus.flush       = flush_r;
   assign bus.redirect_pc = redirect_pc_r;
   assign bus.q_full      = full_s;
   assign bus.err         = err_r;
   assign bus.branch_cnt  = branch_cnt_r;
   assign bus.mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the resolve rules.
module tb_branch_resolve_unit;
   import bru_pkg::*;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = 16;
   localparam int unsigned CMAX = (32'd1 << CNT_W) - 32'd1;

   typedef struct {
      bit            taken;
      bit [PC_W-1:0] alt;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   ent_t          q[$];
   bit            m_err;
   int unsigned   m_bc, m_mc;
   bit            e_upd, e_taken, e_flush;
   bit [PC_W-1:0] e_rpc;

   task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_err = 1'b0; m_bc = 0; m_mc = 0;
      e_upd = 1'b0; e_taken = 1'b0; e_flush = 1'b0; e_rpc = '0;
   endtask

   task automatic check_all(string tag);
      check_eq({tag, ".upd_en"},      64'(bus.upd_en),      64'(e_upd));
      check_eq({tag, ".upd_taken"},   64'(bus.upd_taken),   64'(e_taken));
      check_eq({tag, ".flush"},       64'(bus.flush),       64'(e_flush));
      if (e_flush || !rst_n)
         check_eq({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(e_rpc));
      check_eq({tag, ".err"},         64'(bus.err),         64'(m_err));
      check_eq({tag, ".branch_cnt"},  64'(bus.branch_cnt),  64'(m_bc));
      check_eq({tag, ".mispred_cnt"}, 64'(bus.mispred_cnt), 64'(m_mc));
      check_eq({tag, ".q_full"},      64'(bus.q_full),      64'(q.size() == DEPTH));
   endtask

   // One clock: drive inputs, advance model, check after the edge.
   task automatic step(string tag, bit pv, bit pt, bit [PC_W-1:0] pa, bit rv, bit rt);
      bit   full, pop_ok, mis;
      ent_t h, n;
      bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_alt_pc = pa;
      bus.res_valid  = rv; bus.res_taken  = rt;
      full   = (q.size() == DEPTH);
      pop_ok = rv && (q.size() > 0);
      mis    = 1'b0;
      check_eq({tag, ".q_full_pre"}, 64'(bus.q_full), 64'(full));
      e_upd = 1'b0; e_taken = 1'b0; e_flush = 1'b0; e_rpc = '0;
      if (pv && full && !pop_ok) m_err = 1'b1;
      if (rv && q.size() == 0)   m_err = 1'b1;
      if (pop_ok) begin
         h = q.pop_front();
         e_upd = 1'b1; e_taken = rt;
         if (m_bc < CMAX) m_bc++;
         if (h.taken != rt) begin
            mis = 1'b1; e_flush = 1'b1; e_rpc = h.alt;
            if (m_mc < CMAX) m_mc++;
            q.delete();
         end
      end
      if (pv && !mis && (!full || pop_ok)) begin
         n.taken = pt; n.alt = pa;
         q.push_back(n);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(string tag);
      step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(string tag);
      rst_n = 1'b0;
      bus.pred_valid = 1'b0; bus.res_valid = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.pred_valid = 1'b0; bus.pred_taken = 1'b0; bus.pred_alt_pc = '0;
      bus.res_valid  = 1'b0; bus.res_taken  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // correct prediction
      step("push_t", 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      step("res_hit", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      check_eq("hit.bc", 64'(bus.branch_cnt), 64'd1);
      idle("after_hit");

      // mispredict
      step("push_nt", 1'b1, 1'b0, 32'h0000_2040, 1'b0, 1'b0);
      step("res_miss", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      check_eq("miss.redirect", 64'(bus.redirect_pc), 64'h2040);
      idle("after_miss");

      // fill, overflow, push with pop while full, drain
      for (int i = 0; i < DEPTH; i++)
         step("fill", 1'b1, 1'b1, 32'(32'h1000 + i), 1'b0, 1'b0);
      step("overflow", 1'b1, 1'b1, 32'h9999, 1'b0, 1'b0);
      step("push_pop_full", 1'b1, 1'b1, 32'h7777, 1'b1, 1'b1);
      for (int i = 0; i < DEPTH; i++)
         step("drain", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      do_reset("reset2");

      // mispredict with simultaneous push, then resolve on empty
      step("p1", 1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
      step("p2", 1'b1, 1'b1, 32'h0000_3004, 1'b0, 1'b0);
      step("miss_push", 1'b1, 1'b1, 32'h0000_3008, 1'b1, 1'b0);
      step("res_empty", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      do_reset("reset3");

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0));

      // reset in mid-cycle with three entries queued
      do_reset("reset4");
      for (int i = 0; i < 3; i++)
         step("preload", 1'b1, 1'b1, 32'(32'h4000 + i), 1'b0, 1'b0);
      #2;
      do_reset("reset_mid");
      idle("post_reset_mid");

      // counter saturation: keep one entry in flight, resolve every cycle
      step("sat_seed", 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0);
      for (int i = 0; i < 65536; i++)
         step("sat", 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1);
      check_eq("sat.bc", 64'(bus.branch_cnt), 64'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side partner of the two-level branch predictor. It queues each prediction issued at fetch and compares it, in order, against the actual outcome resolved in EX. It then drives the predictor's training inputs (`en`, `real_br_taken`) and, on a mispredict, issues a one-cycle flush with the recovery PC. It also keeps saturating branch and mispredict statistics.

## Interface
- `DEPTH`, 4: in-flight prediction queue entries; must be a power of 2, ≥2.
- `PC_W`, 32: PC width.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pred_valid` in 1: fetch issued a prediction this cycle.
- `pred_taken` in 1: predicted direction (predictor's `pre_taken`).
- `pred_alt_pc` in PC_W: PC of the path not chosen, used for recovery.
- `res_valid` in 1: EX resolved the oldest outstanding branch.
- `res_taken` in 1: actual direction.
- `upd_en` out 1: predictor training strobe (to `en`).
- `upd_taken` out 1: actual outcome (to `real_br_taken`).
- `flush` out 1: squash younger instructions.
- `redirect_pc` out PC_W: fetch redirect target, valid while `flush`=1.
- `q_full` out 1: queue full; fetch must stall branch issue.
- `err` out 1: sticky protocol error.
- `branch_cnt` out CNT_W: resolved branches.
- `mispred_cnt` out CNT_W: mispredicts.

## Operation
- Queue entry: {`pred_taken`, `pred_alt_pc`}. Push on `pred_valid`. Pop on `res_valid`. Strict FIFO order.
- Resolve compares the head entry's `pred_taken` against `res_taken`:
  - Match: `upd_en`=1 and `upd_taken`=`res_taken` next cycle. No flush.
  - Mismatch: same training pulse. Also `flush`=1 and `redirect_pc`=head `pred_alt_pc` next cycle. The entire queue is cleared: rd/wr pointers reset and count=0.
- Simultaneous push and pop, no mismatch: both occur; count is unchanged. A push is legal when full if a pop occurs in the same cycle.
- Simultaneous push and mispredicting pop: the push is discarded, because it is a younger, squashed branch. Count becomes 0.
- `pred_valid` while full without a pop: push dropped, `err` set.
- `res_valid` while empty: ignored. No update and no counter change; `err` set.
- `branch_cnt` increments on every valid resolve. `mispred_cnt` increments on mismatches. Both saturate at all-ones.
- `err` clears only on reset.

## Timing
- Reset (async assert, sync-safe deassert via clock edge): queue empty; `upd_en`, `upd_taken`, `flush`, `err`=0; `redirect_pc`=0; counters=0; `q_full`=0.
- `upd_en`, `upd_taken`, `flush`, `redirect_pc` are registered. They assert exactly 1 cycle after the `res_valid` edge, for 1 cycle.
- `q_full` is combinational from count (count==DEPTH) and reflects the current-cycle state.
- Counters update on the same edge that registers `upd_en`.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Back-to-back resolves every cycle are supported at full throughput.
- A reset mid-operation drops all in-flight entries. No flush is emitted.

## Structure
- Shared package `bru_pkg`: `bru_entry_t` struct {taken, alt_pc}, default `DEPTH`/`PC_W`/`CNT_W` constants.
- Sub-module `bru_pred_fifo`: holds storage, pointers and count, with push/pop/clear inputs and full/empty/head outputs.
- The top level holds the compare, output registers, counters and error logic.

## Test plan
- Reset, then push taken/alt=0x100, then resolve taken → `upd_en`=1, `upd_taken`=1, `flush`=0, `branch_cnt`=1, `mispred_cnt`=0.
- Push not-taken/alt=0x2040, then resolve taken → next cycle `flush`=1, `redirect_pc`=0x2040, `mispred_cnt`=1, queue empty.
- Push 4 entries (DEPTH=4) → `q_full`=1. A 5th push without a pop → dropped, `err`=1. A push with a simultaneous pop → accepted, count stays 4.
- Queue holds 2 entries; mispredicting resolve plus simultaneous push → count=0, next `res_valid` → ignored, `err`=1.
- Preload `branch_cnt` to 0xFFFF via 65535 resolves, then one more → stays 0xFFFF.
- Assert `rst_n`=0 with 3 entries queued → all outputs 0 immediately; after release `q_full`=0 and count=0.
